mem_unit: RTL and testbench

Unified instruction/data memory that the multi-cycle MIPS core talks to for both fetch and load/store. It serves one outstanding word request at a time with a configurable fixed latency, using a req/ready handshake. It flags misaligned or out-of-range accesses with an error response instead of touching storage. It sits directly below the processor top and is the only memory in the system.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_array.sv | 35 +++
 rtl/mem_unit.sv | 113 +++++++++++
 tb/tb_mem_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    // Misaligned or beyond the last stored word; upper address bits never alias.
    function automatic logic is_bad_addr(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] idx;
        idx = addr >> $clog2(WORD_BYTES);
        return (addr[1:0] != 2'b00) || (idx >= depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with registered read and per-byte-lane write.
// Storage contents survive reset; only the read register is cleared.
module mem_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_unit.sv
// Unified fetch/load/store memory: one outstanding request, fixed latency.
// Optional byte-lane writes when MEM_BYTE_WRITE_EN is defined (adds port be).
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | counting down latency, then completing the captured access
module mem_unit
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef MEM_BYTE_WRITE_EN
    input  logic [3:0]        be,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              err_pending;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic              access_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            err_pending <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            ready       <= 1'b0;
            err         <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        idx_q   <= addr[IDX_W+1:2];
                        wdata_q <= wdata;
                        state   <= WAIT;
                        // Rejected accesses answer on the next edge whatever LATENCY is.
                        if (is_bad_addr(32'(addr), DEPTH)) begin
                            cnt         <= '0;
                            err_pending <= 1'b1;
                        end else begin
                            cnt         <= CNT_W'(LATENCY - 1);
                            err_pending <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ready <= 1'b1;
                        err   <= err_pending;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_BYTE_WRITE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            be_q <= '0;
        end else if (state == IDLE && req) begin
            be_q <= be;
        end
    end
`else
    assign be_q = 4'hF;
`endif

    // Storage is touched only on the completing edge of a good access.
    assign access_en = (state == WAIT) && (cnt == '0) && !err_pending;

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (access_en),
        .we    (we_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .be    (be_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit with a LATENCY=2 and a LATENCY=1 instance.
module tb_mem_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req1, req2, we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata1, rdata2;
    logic        ready1, ready2, err1, err2;
`ifdef MEM_BYTE_WRITE_EN
    logic [3:0]  be;
`endif

    mem_unit #(.DEPTH(256), .LATENCY(2), .ADDR_W(32), .DATA_W(32)) u_dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_WRITE_EN
        .be(be),
`endif
        .rdata(rdata2), .ready(ready2), .err(err2)
    );

    mem_unit #(.DEPTH(256), .LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_WRITE_EN
        .be(be),
`endif
        .rdata(rdata1), .ready(ready1), .err(err1)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] model1 [256];
    logic [31:0] model2 [256];
    logic [31:0] last1, last2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected result is built from a word-level reference model, pushed on
    // drive and popped when the selected instance pulses ready.
    task automatic access(input bit sel, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] lanes, input string tag);
        exp_t        e, got;
        logic [31:0] cur;
        int          cyc;
        logic        rdy;
        if (a[1:0] != 2'b00 || a >= 32'h400) begin
            e.err   = 1'b1;
            e.rdata = sel ? last1 : last2;
            e.lat   = 2;
        end else begin
            e.err = 1'b0;
            e.lat = sel ? 2 : 3;
            cur   = sel ? model1[a[9:2]] : model2[a[9:2]];
            if (w) begin
                for (int i = 0; i < 4; i++) if (lanes[i]) cur[8*i +: 8] = d[8*i +: 8];
                if (sel) model1[a[9:2]] = cur; else model2[a[9:2]] = cur;
                e.rdata = sel ? last1 : last2;
            end else begin
                e.rdata = cur;
                if (sel) last1 = cur; else last2 = cur;
            end
        end
        @(negedge clk);
        we = w; addr = a; wdata = d;
`ifdef MEM_BYTE_WRITE_EN
        be = lanes;
`endif
        if (sel) req1 = 1'b1; else req2 = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req1 = 1'b0; req2 = 1'b0;
        addr = a ^ 32'hFFFF_FFF0; wdata = ~d; we = ~w;
        cyc = 0; rdy = 1'b0;
        while (!rdy && cyc < 20) begin
            @(negedge clk);
            cyc++;
            rdy = sel ? ready1 : ready2;
        end
        got = sb.pop_front();
        chk({tag, " ready"}, 32'(rdy), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(got.lat));
        chk({tag, " err"}, 32'(sel ? err1 : err2), 32'(got.err));
        chk({tag, " rdata"}, sel ? rdata1 : rdata2, got.rdata);
        @(negedge clk);
        chk({tag, " pulse"}, 32'(sel ? ready1 : ready2), 32'd0);
    endtask

    initial begin
        exp_t got, e;
        int   k, cyc, last_cyc, n;

        reset = 1'b0; req1 = 1'b0; req2 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef MEM_BYTE_WRITE_EN
        be = 4'hF;
`endif
        last1 = '0; last2 = '0;
        repeat (2) @(negedge clk);
        chk("rst ready2", 32'(ready2), 32'd0);
        chk("rst err2", 32'(err2), 32'd0);
        chk("rst rdata2", rdata2, 32'd0);
        chk("rst ready1", 32'(ready1), 32'd0);
        chk("rst rdata1", rdata1, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "wr10");
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, "rd10");
        access(0, 1'b0, 32'h12, 32'h0, 4'hF, "rd_mis");
        access(0, 1'b0, 32'h400, 32'h0, 4'hF, "rd_oor");
        access(0, 1'b1, 32'h0, 32'hA5A5_0000, 4'hF, "wr0");
        access(0, 1'b1, 32'h400, 32'h5555_5555, 4'hF, "wr_oor");
        access(0, 1'b1, 32'h3, 32'h6666_6666, 4'hF, "wr_mis");
        access(0, 1'b0, 32'h0, 32'h0, 4'hF, "rd0_noalias");
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, "rd10_again");
        access(0, 1'b1, 32'h0, 32'h1111_1111, 4'hF, "wr0b");
        access(0, 1'b1, 32'h4, 32'h2222_2222, 4'hF, "wr4");

        // req held high: one acceptance per LATENCY+1 cycles, alternating 0x0/0x4.
        @(negedge clk);
        we = 1'b0; addr = 32'h0; req2 = 1'b1;
        e.err = 1'b0; e.rdata = model2[0]; e.lat = 3;
        sb.push_back(e);
        k = 0; cyc = 0; last_cyc = 0;
        while (k < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ready2) begin
                got = sb.pop_front();
                chk("b2b rdata", rdata2, got.rdata);
                chk("b2b err", 32'(err2), 32'(got.err));
                chk("b2b spacing", 32'(cyc - last_cyc), 32'(got.lat));
                last_cyc = cyc;
                k++;
                addr = k[0] ? 32'h4 : 32'h0;
                if (k == 6) begin
                    req2 = 1'b0;
                end else begin
                    e.rdata = k[0] ? model2[1] : model2[0];
                    sb.push_back(e);
                end
            end
        end
        req2 = 1'b0;
        chk("b2b count", 32'(k), 32'd6);
        last2 = model2[1];
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready2) n++;
        end
        chk("b2b no extra", 32'(n), 32'd0);

        // Reset while a write is in WAIT must abort it.
        access(0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, "wr20");
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; req2 = 1'b1;
        @(posedge clk);
        #1;
        req2 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst ready", 32'(ready2), 32'd0);
        chk("midrst rdata", rdata2, 32'd0);
        reset = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready2) n++;
        end
        chk("midrst no ready", 32'(n), 32'd0);
        last1 = '0; last2 = '0;
        access(0, 1'b0, 32'h20, 32'h0, 4'hF, "rd20_after_rst");

        access(1, 1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, "l1_wr8");
        access(1, 1'b0, 32'h8, 32'h0, 4'hF, "l1_rd8");
        access(1, 1'b0, 32'h6, 32'h0, 4'hF, "l1_mis");
        access(1, 1'b0, 32'h8, 32'h0, 4'hF, "l1_rd8_again");

`ifdef MEM_BYTE_WRITE_EN
        access(0, 1'b1, 32'h30, 32'hAABB_CCDD, 4'hF, "be_full");
        access(0, 1'b1, 32'h30, 32'h1122_3344, 4'b0101, "be_0101");
        access(0, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0000, "be_none");
        access(0, 1'b0, 32'h30, 32'h0, 4'hF, "be_rd30");
        chk("be_rd30 value", rdata2, 32'hAA22_CC44);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
